// File: rtl/issue_pipe_reg_pkg.sv
// Shared definitions for the issue pipeline register: state encoding,
// flush-cause constants and the NOP payload fill value.
package issue_pipe_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } issue_state_e;

  localparam logic CAUSE_EXC     = 1'b0;
  localparam logic CAUSE_MISPRED = 1'b1;

  // Every bit of a NOP payload takes this value.
  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/issue_pipe_reg_if.sv
// Issue-group stream: per-lane valid, packed payload and a single ready.
// valid/ready: a group transfers on a rising edge where valid!=0 and ready=1.
interface issue_pipe_reg_if #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 160
);
  logic [LANES-1:0]           valid;
  logic [LANES*PAYLOAD_W-1:0] payload;
  logic                       ready;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/issue_lane_mask.sv
// Turns a surviving-lane count into a mask of the lowest-index lanes,
// clamping counts above LANES.
module issue_lane_mask #(
  parameter int LANES = 2,
  parameter int KW    = $clog2(LANES + 1)
) (
  input  logic [KW-1:0]    keep_lanes_i,
  output logic [LANES-1:0] mask_o
);

  int keep_n;

  always_comb begin
    keep_n = (int'(keep_lanes_i) > LANES) ? LANES : int'(keep_lanes_i);
    for (int i = 0; i < LANES; i++) begin
      mask_o[i] = (i < keep_n);
    end
  end

endmodule

// File: rtl/issue_pipe_reg.sv
// Issue-to-execute pipeline register with a one-group skid buffer,
// exception/misprediction flush and a saturating stall counter.
module issue_pipe_reg
  import issue_pipe_reg_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 160,
  parameter int CNT_W     = 32,
  parameter int KW        = $clog2(LANES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  issue_pipe_reg_if.slave     up,
  issue_pipe_reg_if.master    dn,
  input  logic                flush,
  input  logic                flush_cause,
  input  logic [KW-1:0]       keep_lanes,
  output logic [CNT_W-1:0]    stall_cnt,
  output issue_state_e        state_dbg_o
);

  localparam int PW = LANES * PAYLOAD_W;

  issue_state_e     state_q, state_d;
  logic [LANES-1:0] main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [PW-1:0]    main_p_q, main_p_d, skid_p_q, skid_p_d;
  logic [CNT_W-1:0] stall_q;

  logic             in_ready, accept, drain, stalled;
  logic [LANES-1:0] keep_mask;
  logic [PW-1:0]    in_p_clean;

  issue_lane_mask #(.LANES(LANES), .KW(KW)) u_lane_mask (
    .keep_lanes_i (keep_lanes),
    .mask_o       (keep_mask)
  );

  assign in_ready = (state_q != ST_SKID);
  assign accept   = in_ready && (|up.valid) && !flush;
  assign drain    = (state_q != ST_EMPTY) && dn.ready;
  assign stalled  = (|main_v_q) && !dn.ready;

  // Invalid lanes are stored as NOPs so downstream never sees stale bits.
  always_comb begin
    in_p_clean = '0;
    for (int i = 0; i < LANES; i++) begin
      in_p_clean[i*PAYLOAD_W +: PAYLOAD_W] =
        up.valid[i] ? up.payload[i*PAYLOAD_W +: PAYLOAD_W] : {PAYLOAD_W{NOP_BIT}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      main_v_q <= '0;
      main_p_q <= '0;
      skid_v_q <= '0;
      skid_p_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      main_v_q <= main_v_d;
      main_p_q <= main_p_d;
      skid_v_q <= skid_v_d;
      skid_p_q <= skid_p_d;
      if (stalled && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    main_v_d = main_v_q;
    main_p_d = main_p_q;
    skid_v_d = skid_v_q;
    skid_p_d = skid_p_q;
    if (flush) begin
      skid_v_d = '0;
      skid_p_d = '0;
      // A same-cycle drain already hands main downstream, so nothing survives.
      if ((flush_cause == CAUSE_EXC) || drain) begin
        main_v_d = '0;
        main_p_d = '0;
      end else begin
        main_v_d = main_v_q & keep_mask;
        for (int i = 0; i < LANES; i++) begin
          if (!keep_mask[i]) main_p_d[i*PAYLOAD_W +: PAYLOAD_W] = {PAYLOAD_W{NOP_BIT}};
        end
      end
      state_d = (|main_v_d) ? ST_FULL : ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_v_d = up.valid;
            main_p_d = in_p_clean;
            state_d  = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            main_v_d = up.valid;
            main_p_d = in_p_clean;
          end else if (drain) begin
            main_v_d = '0;
            main_p_d = '0;
            state_d  = ST_EMPTY;
          end else if (accept) begin
            skid_v_d = up.valid;
            skid_p_d = in_p_clean;
            state_d  = ST_SKID;
          end
        end
        ST_SKID: begin
          if (drain) begin
            main_v_d = skid_v_q;
            main_p_d = skid_p_q;
            skid_v_d = '0;
            skid_p_d = '0;
            state_d  = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    up.ready    = in_ready;
    dn.valid    = main_v_q;
    dn.payload  = main_p_q;
    stall_cnt   = stall_q;
    state_dbg_o = state_q;
  end

endmodule

// File: doc/issue_pipe_reg.md
ISSUE_PIPE_REG -- requirements
Module: issue_pipe_reg

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes (1..4).
REQ-002 Parameter PAYLOAD_W, default 160, per-lane payload bits (aluop, alusel, operands, waddr, we, exception type, delay-slot flag, ...).
REQ-003 Parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  LANES  per-lane valid from the upstream stage.
REQ-007 in_payload  in  LANES*PAYLOAD_W  lane i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-008 in_ready  out  1  stage can accept an issue group this cycle.
REQ-009 out_valid  out  LANES  per-lane valid to the execute stage.
REQ-010 out_payload  out  LANES*PAYLOAD_W  payload to the execute stage.
REQ-011 out_ready  in  1  execute stage accepts the current group.
REQ-012 flush  in  1  flush request.
REQ-013 flush_cause  in  1  0 = exception, 1 = failed branch prediction.
REQ-014 keep_lanes  in  $clog2(LANES+1)  on misprediction, the count of lowest-index held lanes that survive (delay slot).
REQ-015 stall_cnt  out  CNT_W  saturating count of cycles with out_valid!=0 and out_ready=0.

Function
REQ-016 A group is one set of LANES lanes moved together; "group valid" SHALL mean any bit of its valid vector is set.
REQ-017 Storage SHALL be a main register (drives outputs) and a one-group skid register.
REQ-018 States SHALL be EMPTY (neither holds a group), FULL (main only) and SKID (main and skid).
REQ-019 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID, driven only from state.
REQ-020 Accept SHALL occur when in_ready=1, in_valid!=0 and flush=0.
REQ-021 Drain SHALL occur when main is valid and out_ready=1.
REQ-022 EMPTY: accept -> FULL, with the group in main; latency from accept to output is 1 cycle.
REQ-023 FULL: accept and drain -> FULL, with the new group in main.
REQ-024 FULL: drain only -> EMPTY.
REQ-025 FULL: accept without drain -> SKID, with the new group in skid.
REQ-026 FULL: neither -> hold.
REQ-027 SKID: drain -> FULL, with skid moved to main; otherwise hold.
REQ-028 Order SHALL be preserved; no group is duplicated or dropped except by flush.
REQ-029 Exception flush (flush=1, cause=0) SHALL clear main and skid; the state goes to EMPTY next cycle.
REQ-030 Misprediction flush (flush=1, cause=1) SHALL keep main lanes with index < keep_lanes.
REQ-031 Misprediction flush SHALL clear the other main lanes and the whole skid group.
REQ-032 After a misprediction flush, the state SHALL be FULL if any main lane survives, else EMPTY.
REQ-033 On any flush, input that cycle SHALL be discarded; an out_ready handshake that cycle SHALL still drain main, in which case no lane survives.
REQ-034 keep_lanes > LANES SHALL be treated as LANES.
REQ-035 Every invalid lane SHALL present out_payload bits of zero (NOP encoding); cleared lanes SHALL be zeroed, not merely invalidated.
REQ-036 in_valid lanes that are 0 in an accepted group SHALL store zero payload.
REQ-037 stall_cnt SHALL increment by 1 per stalled cycle and saturate at all-ones.
REQ-038 stall_cnt SHALL clear only on reset.

Reset
REQ-039 While reset=1: state EMPTY, all valid bits 0, all payload bits 0, stall_cnt 0, in_ready 1.
REQ-040 Reset assertion mid-transfer SHALL discard all groups immediately (asynchronous).
REQ-041 The first accept after reset SHALL be possible on the first clk edge with reset low.

Structure
REQ-042 State encoding (EMPTY/FULL/SKID), the flush_cause constants (exception / failed branch prediction) and the NOP payload value SHALL live in the shared defines package.
REQ-043 One sub-module, issue_lane_mask, SHALL generate the LANES-bit keep mask from keep_lanes (including the REQ-034 clamp); it is purely combinational.
REQ-044 Everything else SHALL be in issue_pipe_reg.

Verification (LANES=2, PAYLOAD_W=8, CNT_W=4)
REQ-045 Pass-through: in_valid=11, payload {B2,A1}, out_ready=1 -> next cycle out_valid=11, out_payload {B2,A1}, in_ready=1.
REQ-046 Backpressure: out_ready=0; accept G1 then G2 -> state SKID, in_ready=0, outputs G1, stall_cnt=1; out_ready=1 -> G1, then G2 on consecutive cycles.
REQ-047 Misprediction: main {B2,A1}, flush=1, cause=1, keep_lanes=1, out_ready=0 -> out_valid=01, lane1 payload 00, skid cleared, in_ready=1.
REQ-048 Exception flush in SKID with in_valid=11 -> next cycle out_valid=00, all payload 00, state EMPTY, input not captured.
REQ-049 Saturation: hold out_ready=0 with a valid group for 20 cycles -> stall_cnt reaches F and stays F.
REQ-050 Async reset asserted between edges while in SKID -> outputs zero and in_ready=1 before the next clk edge.
